// File: rtl/load_extract_unit.sv
// Multicycle load-data unit: aligned memory read, lane select, zero/sign extension, start/done handshake.
// Optional alignment fault detection is enabled by defining LOAD_ALIGN_CHECK_EN.
module load_extract_unit #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        load_size_control,
   input  logic              load_signed,
   input  logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] load_out,
   output logic              misaligned
);

   localparam int OFF = $clog2(DATA_W / 8);
   localparam logic [OFF-1:0] HALF_MASK = {{(OFF-1){1'b1}}, 1'b0};
   localparam logic [OFF-1:0] WORD_MASK = (DATA_W == 64) ? OFF'(4) : '0;

   typedef enum logic [1:0] {IDLE, READ, CAPTURE, DONE} state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic [OFF-1:0]    loff;
   logic [1:0]        lsize;
   logic              lsigned;
   logic [DATA_W-1:0] mdr;

   logic              align_fault;
   logic [OFF-1:0]    lane_off;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] mask;
   logic              sbit;
   logic [DATA_W-1:0] ext;

   always_comb begin
      align_fault = 1'b0;
`ifdef LOAD_ALIGN_CHECK_EN
      case (load_size_control)
         2'b01:   align_fault = addr[0];
         2'b11:   align_fault = (addr[1:0] != 2'b00);
         2'b00:   align_fault = (addr[OFF-1:0] != '0);
         default: align_fault = 1'b0;
      endcase
`endif
   end

   // Lane offset is the latched byte offset rounded down to the access size;
   // with DATA_W=32 the word mask is empty so size 11 collapses to a full load.
   always_comb begin
      lane_off = '0;
      mask     = '1;
      sbit     = 1'b0;
      case (lsize)
         2'b10: begin
            lane_off = loff;
            mask     = DATA_W'(8'hFF);
         end
         2'b01: begin
            lane_off = loff & HALF_MASK;
            mask     = DATA_W'(16'hFFFF);
         end
         2'b11: begin
            lane_off = loff & WORD_MASK;
            mask     = (DATA_W == 64) ? DATA_W'(32'hFFFF_FFFF) : '1;
         end
         default: begin
            lane_off = '0;
            mask     = '1;
         end
      endcase
      shifted = mdr >> {lane_off, 3'b000};
      case (lsize)
         2'b10:   sbit = shifted[7];
         2'b01:   sbit = shifted[15];
         2'b11:   sbit = shifted[31];
         default: sbit = 1'b0;
      endcase
      ext = (shifted & mask) | ((lsigned && sbit) ? ~mask : '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         mem_addr   <= '0;
         mem_rd     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         misaligned <= 1'b0;
         load_out   <= '0;
         cnt        <= '0;
         mdr        <= '0;
         loff       <= '0;
         lsize      <= '0;
         lsigned    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  lsize   <= load_size_control;
                  lsigned <= load_signed;
                  loff    <= addr[OFF-1:0];
                  busy    <= 1'b1;
                  cnt     <= '0;
                  if (align_fault) begin
                     done       <= 1'b1;
                     misaligned <= 1'b1;
                     state      <= DONE;
                  end else begin
                     mem_addr <= {addr[ADDR_W-1:OFF], {OFF{1'b0}}};
                     mem_rd   <= 1'b1;
                     state    <= READ;
                  end
               end
            end
            READ: begin
               if (cnt == 4'(MEM_LAT - 1)) begin
                  mdr    <= mem_rdata;
                  mem_rd <= 1'b0;
                  state  <= CAPTURE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            CAPTURE: begin
               load_out <= ext;
               done     <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               done       <= 1'b0;
               misaligned <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_extract_unit.sv
// Self-checking bench for load_extract_unit: a 32-bit/latency-1 and a 64-bit/latency-4 instance
// driven with directed and random loads, compared against a byte-arithmetic reference model.
module tb_load_extract_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        which;
   logic        start;
   logic [1:0]  sz;
   logic        sg;
   logic [31:0] a;
   logic [63:0] word;

   logic        s32, s64;
   logic [31:0] maddr32, maddr64;
   logic        rd32, rd64, busy32, busy64, done32, done64, mis32, mis64;
   logic [31:0] rdata32, out32;
   logic [63:0] rdata64, out64;

   logic [31:0] s_maddr;
   logic        s_rd, s_busy, s_done, s_mis;
   logic [63:0] s_out;

   logic [63:0] last32, last64;
   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   assign s32     = start & ~which;
   assign s64     = start & which;
   assign rdata32 = rd32 ? word[31:0] : 32'hDEAD_BEEF;
   assign rdata64 = rd64 ? word : 64'hDEAD_BEEF_DEAD_BEEF;

   assign s_maddr = which ? maddr64 : maddr32;
   assign s_rd    = which ? rd64 : rd32;
   assign s_busy  = which ? busy64 : busy32;
   assign s_done  = which ? done64 : done32;
   assign s_mis   = which ? mis64 : mis32;
   assign s_out   = which ? out64 : {32'd0, out32};

   load_extract_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(1)) u32 (
      .clk(clk), .reset(reset), .start(s32), .load_size_control(sz), .load_signed(sg),
      .addr(a), .mem_addr(maddr32), .mem_rd(rd32), .mem_rdata(rdata32), .busy(busy32),
      .done(done32), .load_out(out32), .misaligned(mis32)
   );

   load_extract_unit #(.DATA_W(64), .ADDR_W(32), .MEM_LAT(4)) u64 (
      .clk(clk), .reset(reset), .start(s64), .load_size_control(sz), .load_signed(sg),
      .addr(a), .mem_addr(maddr64), .mem_rd(rd64), .mem_rdata(rdata64), .busy(busy64),
      .done(done64), .load_out(out64), .misaligned(mis64)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int unsigned access_bytes(input int unsigned w, input logic [1:0] z);
      case (z)
         2'b10:   return 1;
         2'b01:   return 2;
         2'b11:   return (w == 64) ? 4 : w / 8;
         default: return w / 8;
      endcase
   endfunction

   function automatic logic [63:0] ref_load(input int unsigned w, input logic [1:0] z, input logic g,
                                            input logic [31:0] ad, input logic [63:0] wd);
      int unsigned nb, off;
      logic [63:0] v, m;
      nb  = access_bytes(w, z);
      off = ad % (w / 8);
      off = off - (off % nb);
      v   = (w == 32) ? (wd & 64'hFFFF_FFFF) : wd;
      v   = v >> (8 * off);
      if (nb < 8) begin
         m = (64'd1 << (8 * nb)) - 64'd1;
         v = v & m;
         if (g && v[8*nb-1]) v = v | ~m;
      end
      if (w == 32) v = v & 64'hFFFF_FFFF;
      return v;
   endfunction

   function automatic logic ref_mis(input int unsigned w, input logic [1:0] z, input logic [31:0] ad);
`ifdef LOAD_ALIGN_CHECK_EN
      return (z != 2'b10) && ((ad % access_bytes(w, z)) != 0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic run_load(input logic w64, input logic [1:0] z, input logic g,
                           input logic [31:0] ad, input logic [63:0] wd, input logic hold);
      int unsigned width, lat, dcyc, rdc;
      logic [63:0] exp, prev;
      logic        mis;
      @(negedge clk);
      which = w64; sz = z; sg = g; a = ad; word = wd; start = 1'b1;
      width = w64 ? 64 : 32;
      lat   = w64 ? 4 : 1;
      prev  = w64 ? last64 : last32;
      exp   = ref_load(width, z, g, ad, wd);
      mis   = ref_mis(width, z, ad);
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      dcyc = 0;
      rdc  = 0;
      for (int unsigned cyc = 1; cyc <= 30 && dcyc == 0; cyc++) begin
         @(negedge clk);
         if (s_rd) begin
            if (rdc == 0) check_eq("mem_addr", 64'(s_maddr), 64'(ad & ~(width / 8 - 1)));
            rdc++;
         end
         if (s_done) begin
            dcyc = cyc;
            check_eq("busy_at_done", 64'(s_busy), 64'd1);
            check_eq("misaligned", 64'(s_mis), 64'(mis));
            check_eq("load_out", s_out, mis ? prev : exp);
         end
      end
      check_eq("done_cycle", 64'(dcyc), mis ? 64'd1 : 64'(lat + 2));
      check_eq("rd_cycles", 64'(rdc), mis ? 64'd0 : 64'(lat));
      @(negedge clk);
      check_eq("done_pulse", 64'(s_done), 64'd0);
      check_eq("busy_after", 64'(s_busy), 64'd0);
      if (hold) begin
         start = 1'b0;
         @(negedge clk);
         check_eq("start_in_done_ignored", 64'(s_busy), 64'd0);
      end
      if (w64) last64 = s_out; else last32 = s_out;
   endtask

   initial begin
      logic [63:0] rword;
      logic        saw_done;
      reset = 1'b1; start = 1'b0; which = 1'b0; sz = 2'b00; sg = 1'b0; a = '0; word = '0;
      last32 = '0; last64 = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_busy", {62'd0, busy64, busy32}, 64'd0);
      check_eq("rst_done", {62'd0, done64, done32}, 64'd0);
      check_eq("rst_rd", {62'd0, rd64, rd32}, 64'd0);
      check_eq("rst_mis", {62'd0, mis64, mis32}, 64'd0);
      check_eq("rst_out64", out64, 64'd0);
      check_eq("rst_out32_addr", {out32, maddr32 | maddr64}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      run_load(1'b0, 2'b10, 1'b1, 32'h0000_1003, 64'h0000_0000_80F1_7F02, 1'b0);
      check_eq("byte_signed", s_out, 64'h0000_0000_FFFF_FF80);
      run_load(1'b0, 2'b01, 1'b0, 32'h0000_1002, 64'h0000_0000_80F1_7F02, 1'b0);
      check_eq("half_unsigned", s_out, 64'h0000_0000_0000_80F1);
      run_load(1'b0, 2'b01, 1'b1, 32'h0000_1002, 64'h0000_0000_80F1_7F02, 1'b0);
      check_eq("half_signed", s_out, 64'h0000_0000_FFFF_80F1);
      run_load(1'b1, 2'b00, 1'b0, 32'h0000_2000, 64'h0000_0000_1234_5678, 1'b0);
      check_eq("full64", s_out, 64'h0000_0000_1234_5678);
      run_load(1'b1, 2'b11, 1'b1, 32'h0000_2004, 64'h8000_0001_0000_0002, 1'b0);
      check_eq("word64_signed", s_out, 64'hFFFF_FFFF_8000_0001);
      run_load(1'b0, 2'b11, 1'b1, 32'h0000_3000, 64'h0000_0000_8765_4321, 1'b0);
      check_eq("word32_as_full", s_out, 64'h0000_0000_8765_4321);
      run_load(1'b0, 2'b01, 1'b0, 32'h0000_4001, 64'h0000_0000_CAFE_F00D, 1'b0);
      run_load(1'b1, 2'b10, 1'b1, 32'h0000_5007, 64'hFE00_0000_0000_0000, 1'b1);

      for (int i = 0; i < 40; i++) begin
         rword = {$urandom, $urandom};
         run_load(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, rword, 1'b0);
      end

      // Abort a 64-bit load part-way through its read phase.
      @(negedge clk);
      which = 1'b1; sz = 2'b00; sg = 1'b0; a = 32'h0000_6000; word = 64'h1111_2222_3333_4444;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("rd_before_abort", 64'(rd64), 64'd1);
      #1;
      reset = 1'b1;
      #1;
      check_eq("abort_rd", 64'(rd64), 64'd0);
      check_eq("abort_busy", 64'(busy64), 64'd0);
      check_eq("abort_out", out64, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      last32 = '0;
      last64 = '0;
      saw_done = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done64 || busy64) saw_done = 1'b1;
      end
      check_eq("no_done_after_abort", 64'(saw_done), 64'd0);
      run_load(1'b1, 2'b00, 1'b0, 32'h0000_6000, 64'h1111_2222_3333_4444, 1'b0);
      check_eq("load_after_abort", s_out, 64'h1111_2222_3333_4444);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
